// File: rtl/cpu_halt_dump.sv
// cpu_halt_dump: holds the core in reset, runs it until halt or timeout, drains,
// then scans data memory and streams (non-zero) words over a valid/ready port.
module cpu_halt_dump #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MEM_DEPTH = 65536,
  parameter logic [4:0] HALT_OP = 5'b11100,
  parameter int RESET_CYCLES = 4,
  parameter int DRAIN_CYCLES = 10,
  parameter int TIMEOUT_W = 32,
  parameter int SKIP_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   instr,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 cpu_reset,
  output logic [TIMEOUT_W-1:0] cycle_count,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [ADDR_W-1:0]    dump_addr,
  output logic [DATA_W-1:0]    dump_data,
  output logic                 done,
  output logic                 timed_out
);
  typedef enum logic [2:0] {HOLD, RUN, DRAIN, READ, CHECK, EMIT, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  state_t r_state;
  logic r_cpu_reset, r_rd_en, r_valid, r_done, r_to;
  logic [TIMEOUT_W-1:0] r_cycle;
  logic [31:0] r_wait;
  logic [ADDR_W-1:0] r_addr, r_daddr;
  logic [DATA_W-1:0] r_ddata;
  logic [INSTR_W-6:0] w_rest;
  logic w_halt, w_last, w_to_hit, w_skip;
  logic [TIMEOUT_W-1:0] w_inc;
  assign w_rest = instr[INSTR_W-6:0];
  assign w_halt = instr[INSTR_W-1 -: 5] == HALT_OP && (&w_rest || ~|w_rest);
  assign w_last = r_addr == LAST;
  assign w_inc = &r_cycle ? r_cycle : r_cycle + TIMEOUT_W'(1);
  // compare against the wrapped sum so a saturated counter never re-matches
  assign w_to_hit = timeout_limit != '0 && r_cycle + TIMEOUT_W'(1) == timeout_limit;
  assign w_skip = SKIP_ZERO != 0 && mem_rdata == '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HOLD;
      r_cpu_reset <= 1'b1;
      r_cycle <= '0;
      r_wait <= '0;
      r_rd_en <= 1'b0;
      r_addr <= '0;
      r_valid <= 1'b0;
      r_daddr <= '0;
      r_ddata <= '0;
      r_done <= 1'b0;
      r_to <= 1'b0;
    end else begin
      case (r_state)
        HOLD:
          if (r_wait == 32'(RESET_CYCLES - 1)) begin
            r_wait <= '0;
            r_cpu_reset <= 1'b0;
            r_state <= RUN;
          end else r_wait <= r_wait + 32'd1;
        RUN: begin
          r_cycle <= w_inc;
          if (w_halt) r_state <= DRAIN;
          else if (w_to_hit) begin
            r_to <= 1'b1;
            r_state <= DRAIN;
          end
        end
        DRAIN:
          if (r_wait == 32'(DRAIN_CYCLES - 1)) begin
            r_wait <= '0;
            r_addr <= '0;
            r_rd_en <= 1'b1;
            r_state <= READ;
          end else r_wait <= r_wait + 32'd1;
        READ: begin
          r_rd_en <= 1'b0;
          r_state <= CHECK;
        end
        CHECK: begin
          r_daddr <= r_addr;
          r_ddata <= mem_rdata;
          if (!w_skip) begin
            r_valid <= 1'b1;
            r_state <= EMIT;
          end else if (w_last) begin
            r_done <= 1'b1;
            r_state <= DONE;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            r_rd_en <= 1'b1;
            r_state <= READ;
          end
        end
        EMIT:
          if (dump_ready) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_done <= 1'b1;
              r_state <= DONE;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
              r_rd_en <= 1'b1;
              r_state <= READ;
            end
          end
        DONE: r_done <= 1'b1;
        default: r_state <= HOLD;
      endcase
    end
  end
  assign cpu_reset = r_cpu_reset;
  assign cycle_count = r_cycle;
  assign mem_rd_en = r_rd_en;
  assign mem_addr = r_addr;
  assign dump_valid = r_valid;
  assign dump_addr = r_daddr;
  assign dump_data = r_ddata;
  assign done = r_done;
  assign timed_out = r_to;
endmodule

// File: tb/tb_cpu_halt_dump.sv
// tb_cpu_halt_dump: directed and randomized runs of cpu_halt_dump (skip-zero and
// emit-all instances) against an expected beat list built from memory contents.
module tb_cpu_halt_dump;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] instr = '0;
  logic [31:0] limit = '0;
  logic dump_ready = 1'b0;
  logic [15:0] mem [16];
  logic [15:0] rdata, rdata0;
  logic cpu_reset, mem_rd_en, dump_valid, done, timed_out;
  logic [31:0] cycle_count;
  logic [15:0] mem_addr, dump_addr, dump_data;
  logic cpu_reset0, rd_en0, valid0, done0, to0;
  logic [31:0] cycle0;
  logic [15:0] addr0, daddr0, ddata0;
  logic [31:0] q[$], q0[$];
  longint last_hs;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_halt_dump #(.MEM_DEPTH(16), .SKIP_ZERO(1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .timeout_limit(limit),
    .cpu_reset(cpu_reset), .cycle_count(cycle_count), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .done(done), .timed_out(timed_out));

  cpu_halt_dump #(.MEM_DEPTH(16), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .reset(reset), .instr(instr), .timeout_limit(limit),
    .cpu_reset(cpu_reset0), .cycle_count(cycle0), .mem_rd_en(rd_en0),
    .mem_addr(addr0), .mem_rdata(rdata0), .dump_valid(valid0),
    .dump_ready(1'b1), .dump_addr(daddr0), .dump_data(ddata0),
    .done(done0), .timed_out(to0));

  // memory answers one cycle after the read strobe
  always @(posedge clk) begin
    if (mem_rd_en) rdata <= mem[mem_addr[3:0]];
    if (rd_en0) rdata0 <= mem[addr0[3:0]];
  end

  always @(posedge clk) begin
    if (!reset && dump_valid && dump_ready) begin
      q.push_back({dump_addr, dump_data});
      last_hs = $time;
    end
    if (!reset && valid0) q0.push_back({daddr0, ddata0});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] nonhalt();
    logic [15:0] v;
    v = 16'($urandom);
    if (v[15:11] == 5'b11100 && (v[10:0] == 11'h000 || v[10:0] == 11'h7ff)) v[0] = ~v[0];
    return v;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_flags"}, {cpu_reset, mem_rd_en, dump_valid, done, timed_out}, 5'b10000);
    chk({tag, "_addr"}, {mem_addr, dump_addr, dump_data}, 48'd0);
    chk({tag, "_cc"}, cycle_count, 0);
  endtask

  task automatic run_case(input logic [15:0] hinstr, input int halt_cyc, input int lim,
                          input bit rmode, input bit bp, input int abort_addr);
    int endc, n;
    bit exp_to, seen, seen0, bp_done;
    logic [31:0] exp_q[$];
    logic [15:0] dir[3];
    logic [15:0] sa, sd;
    dir = '{16'hE001, 16'hE7FE, 16'hC000};
    endc = (halt_cyc != 0 && (lim == 0 || halt_cyc <= lim)) ? halt_cyc : lim;
    exp_to = endc != halt_cyc;
    for (int a = 0; a < 16; a++) if (mem[a] != 16'h0) exp_q.push_back({16'(a), mem[a]});
    reset = 1'b1;
    dump_ready = 1'b0;
    instr = 16'h0;
    limit = lim;
    q.delete();
    q0.delete();
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("hold_cpu_reset", cpu_reset, k < 4);
    end
    chk("run_entry_cc", cycle_count, 0);
    for (int k = 1; k <= endc; k++) begin
      instr = (k == halt_cyc) ? hinstr : (k <= 3 ? dir[k-1] : nonhalt());
      @(negedge clk);
      chk("run_cc", cycle_count, k);
      chk("run_timed_out", timed_out, (k == endc) && exp_to);
    end
    instr = 16'hE000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rd_en && n < 200);
    chk("drain_len", n, 10);
    chk("first_rd_addr", mem_addr, 0);
    chk("cc_frozen", cycle_count, endc);
    chk("core_running", cpu_reset, 0);
    for (int c = 0; c < 2000; c++) begin
      if (abort_addr >= 0 && dump_valid && dump_addr == 16'(abort_addr)) begin
        reset = 1'b1;
        #1;
        chk_reset_outs("abort");
        repeat (2) @(negedge clk);
        return;
      end
      if (bp && dump_valid && !bp_done) begin
        sa = dump_addr;
        sd = dump_data;
        dump_ready = 1'b0;
        repeat (7) begin
          @(negedge clk);
          chk("bp_hold", {dump_valid, mem_rd_en, dump_addr, dump_data}, {2'b10, sa, sd});
        end
        dump_ready = 1'b1;
        @(negedge clk);
        chk("bp_next", {dump_valid, mem_rd_en, mem_addr}, {2'b01, sa + 16'd1});
        bp_done = 1'b1;
      end
      if (done && !seen) begin
        seen = 1'b1;
        chk("done_addr", mem_addr, 15);
        if (exp_q.size() > 0 && exp_q[$][31:16] == 16'd15) chk("done_latency", $time - last_hs, 5);
      end
      if (done0 && !seen0) seen0 = 1'b1;
      if (seen && seen0) break;
      dump_ready = rmode ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
    end
    chk("done_both", {done, done0, dump_valid, valid0}, 4'b1100);
    chk("timed_out", {timed_out, to0}, {exp_to, exp_to});
    chk("final_cc", cycle_count, endc);
    chk("beat_count", q.size(), exp_q.size());
    for (int i = 0; i < q.size() && i < exp_q.size(); i++) chk("beat", q[i], exp_q[i]);
    chk("beat_count0", q0.size(), 16);
    for (int i = 0; i < q0.size() && i < 16; i++) chk("beat0", q0[i], {16'(i), mem[i]});
  endtask

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = 16'h0;
    mem[5] = 16'h1234;
    mem[15] = 16'h0001;
    run_case(16'hE000, 20, 0, 1'b0, 1'b0, -1);
    for (int a = 0; a < 16; a++) mem[a] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
    mem[0] = 16'h0; mem[1] = 16'h0; mem[2] = 16'h0; mem[3] = 16'hBEEF;
    run_case(16'hE7FF, 30, 0, 1'b1, 1'b1, -1);
    run_case(16'hE000, 0, 100, 1'b0, 1'b0, -1);
    run_case(16'hE000, 100, 100, 1'b1, 1'b0, -1);
    mem[7] = 16'h7777;
    run_case(16'hE000, 12, 0, 1'b0, 1'b0, 7);
    run_case(16'hE000, 12, 0, 1'b0, 1'b0, -1);
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 16; a++) mem[a] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
      run_case($urandom_range(0, 1) ? 16'hE7FF : 16'hE000, $urandom_range(4, 60),
               $urandom_range(0, 1) ? 0 : $urandom_range(4, 60), 1'b1, 1'b0, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_halt_dump.md
Name: cpu_halt_dump

Overview:
- Synthesizable run controller that sits beside the 16-bit cpu core.
- Holds the core in reset for a programmable number of cycles, then counts run cycles.
- Detects the halt instruction (or a run-cycle timeout) and lets the pipeline drain.
- Then walks data memory and streams every non-zero word out over a valid/ready port, for on-chip or emulator result capture.

Parameters:
- INSTR_W, 16, instruction width.
- ADDR_W, 16, data-memory address width.
- DATA_W, 16, data-memory word width.
- MEM_DEPTH, 65536, number of words to scan; last address is MEM_DEPTH-1. Must be ≤ 2**ADDR_W.
- HALT_OP, 5'b11100, opcode in instr[INSTR_W-1:INSTR_W-5] that marks halt.
- RESET_CYCLES, 4, cycles cpu_reset is held after reset deasserts (≥1).
- DRAIN_CYCLES, 10, cycles waited after halt/timeout before scanning (≥1).
- TIMEOUT_W, 32, width of the cycle counter and timeout limit.
- SKIP_ZERO, 1, when 1 zero words are not emitted; when 0 every word is emitted.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  INSTR_W  instruction currently fetched by the core.
- timeout_limit  in  TIMEOUT_W  maximum run cycles; 0 disables the timeout.
- cpu_reset  out  1  reset to the core.
- cycle_count  out  TIMEOUT_W  run cycles counted.
- mem_rd_en  out  1  data-memory read strobe.
- mem_addr  out  ADDR_W  data-memory read address.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  dump sink ready.
- dump_addr  out  ADDR_W  address of the dumped word.
- dump_data  out  DATA_W  dumped word.
- done  out  1  scan complete; sticky until reset.
- timed_out  out  1  run ended by timeout rather than halt; sticky.

Behaviour:
- Reset (async, immediate):
  - State goes to HOLD.
  - cpu_reset=1.
  - cycle_count=0, hold/drain counters=0.
  - mem_rd_en=0, mem_addr=0.
  - dump_valid=0, dump_addr=0, dump_data=0.
  - done=0, timed_out=0.
  - Reset asserted in any state, including mid-dump, aborts and restarts the whole sequence.
- Halt detect is combinational on instr:
  - instr[INSTR_W-1:INSTR_W-5]==HALT_OP, AND
  - the remaining INSTR_W-5 bits are all 0 or all 1.
  - With defaults, only 0xE000 and 0xE7FF halt.
- HOLD:
  - cpu_reset=1 for exactly RESET_CYCLES rising edges after reset deasserts.
  - cpu_reset is 0 from the cycle RUN is entered.
- RUN:
  - cycle_count increments every cycle (saturates at all-ones).
  - Halt detected: go to DRAIN. cycle_count takes its incremented value on that edge, then freezes.
  - Otherwise, if timeout_limit≠0 and cycle_count+1==timeout_limit: set timed_out=1, go to DRAIN.
  - Halt and timeout in the same cycle: halt wins, timed_out stays 0.
- DRAIN:
  - Core keeps running (cpu_reset=0).
  - Wait DRAIN_CYCLES cycles, then go to READ with mem_addr=0.
- READ:
  - mem_rd_en=1 for exactly one cycle at mem_addr, then go to CHECK.
- CHECK (mem_rdata valid this cycle):
  - Capture mem_rdata into dump_data and mem_addr into dump_addr.
  - If SKIP_ZERO=1 and mem_rdata==0: word is skipped.
    - mem_addr==MEM_DEPTH-1: go to DONE.
    - Otherwise: mem_addr+1, go to READ.
  - Otherwise go to EMIT.
- EMIT:
  - dump_valid=1.
  - dump_addr and dump_data are held stable until dump_valid&&dump_ready.
  - No memory reads are issued while waiting.
  - On handshake, dump_valid=0 on the next cycle.
    - Last address: go to DONE.
    - Otherwise: mem_addr+1, go to READ.
  - Throughput is at most one beat per 3 cycles.
- DONE:
  - done=1; all other outputs hold.
  - The core is not re-reset.
  - No wrap: mem_addr never increments past MEM_DEPTH-1.
- Skipped words never raise dump_valid.
- dump_ready is ignored outside EMIT.

Test Plan:
1. Reset sequence: hold reset 3 cycles, release → cpu_reset=1 for exactly 4 edges, then 0; cycle_count=0 at RUN entry.
2. Halt and dump (MEM_DEPTH=16, SKIP_ZERO=1):
   - Stimulus: instr=0xE000 on RUN cycle 20; mem[5]=0x1234, mem[15]=0x0001, all others 0; dump_ready=1.
   - Response: cycle_count frozen at 20; first mem_rd_en exactly 10 cycles after the halt cycle at addr 0; exactly two beats, (5,0x1234) then (15,0x0001); done=1 one cycle after the second handshake; timed_out=0.
3. Halt decode:
   - 0xE7FF → halt.
   - 0xE001, 0xE7FE, 0xC000 → no halt; RUN continues and cycle_count keeps incrementing.
4. Backpressure: dump_ready=0 for 7 cycles during EMIT → dump_valid=1 with addr/data stable all 7 cycles, mem_rd_en=0; handshake on ready → next read at addr+1.
5. Timeout:
   - timeout_limit=100, no halt → timed_out=1 as cycle_count reaches 100, then drain and dump proceed normally.
   - Rerun with instr=0xE000 on cycle 100 → timed_out=0.
6. Reset and SKIP_ZERO=0:
   - Assert reset during EMIT of addr 7 → all outputs return to reset values immediately (cpu_reset=1) and the sequence restarts from HOLD.
   - With SKIP_ZERO=0 and MEM_DEPTH=16, exactly 16 beats (addresses 0..15) occur before done.
